// File: rtl/cmd_line_decoder_if.sv
// Character stream in, decoded operands and command pulses out.
// The master side is the terminal; the slave side is the decoder.
interface cmd_line_decoder_if #(
   parameter int unsigned OPW = 8
);
   logic [7:0]     char_in;
   logic           char_valid;
   logic           char_ready;
   logic [OPW-1:0] a_in;
   logic [OPW-1:0] b_in;
   logic [10:0]    op_code;
   logic           reset;
   logic           go;
   logic           err;

   modport master (
      output char_in, char_valid,
      input  char_ready, a_in, b_in, op_code, reset, go, err
   );

   modport slave (
      input  char_in, char_valid,
      output char_ready, a_in, b_in, op_code, reset, go, err
   );
endinterface

// File: rtl/cmd_line_decoder.sv
// Line-buffered command decoder: collects characters with backspace, then on Enter
// matches a keyword or scans "A op B" one character per cycle and pulses go/reset/err.
module cmd_line_decoder #(
   parameter int unsigned MAX_CHARS = 8,
   parameter int unsigned OPW       = 8
) (
   input logic               clk,
   input logic               rst_n,
   cmd_line_decoder_if.slave bus
);
   localparam int unsigned LenW = $clog2(MAX_CHARS + 1);
   localparam int unsigned AccW = OPW + 4;

   typedef enum logic [1:0] {StCollect, StKeyw, StScan, StDone} state_e;

   state_e                     state_q, state_d;
   logic [MAX_CHARS-1:0][7:0]  line_q, line_d;
   logic [LenW-1:0]            len_q, len_d, idx_q, idx_d;
   logic                       ovf_q, ovf_d;
   logic [AccW-1:0]            acc_q, acc_d;
   logic [OPW-1:0]             opa_q, opa_d;
   logic [10:0]                opc_q, opc_d;
   logic                       have_op_q, have_op_d, a_dig_q, a_dig_d, a_sp_q, a_sp_d;
   logic                       b_dig_q, b_dig_d, bad_q, bad_d;
   logic [OPW-1:0]             a_q, a_d, b_q, b_d;
   logic [10:0]                op_q, op_d;
   logic                       go_q, go_d, reset_q, reset_d, err_q, err_d;

   logic [7:0]      cur_ch;
   logic            is_dig, is_op, bad_nx;
   logic [10:0]     op_sel;
   logic [AccW-1:0] acc_nx;
   logic [39:0]     first5;
   logic            kw_len;

   always_comb begin
      cur_ch = '0;
      for (int i = 0; i < MAX_CHARS; i++) begin
         if (LenW'(i) == idx_q) cur_ch = line_q[i];
      end
      is_dig = (cur_ch >= 8'h30) && (cur_ch <= 8'h39);
      acc_nx = (acc_q << 3) + (acc_q << 1) + AccW'(cur_ch[3:0]);
      case (cur_ch)
         8'h2B:   op_sel = 11'h001;
         8'h2D:   op_sel = 11'h002;
         8'h2A:   op_sel = 11'h004;
         8'h2F:   op_sel = 11'h008;
         default: op_sel = 11'h000;
      endcase
      is_op  = op_sel != 11'h000;
      first5 = {line_q[0], line_q[1], line_q[2], line_q[3], line_q[4]};
      kw_len = len_q == LenW'(5);
   end

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      len_d     = len_q;
      idx_d     = idx_q;
      ovf_d     = ovf_q;
      acc_d     = acc_q;
      opa_d     = opa_q;
      opc_d     = opc_q;
      have_op_d = have_op_q;
      a_dig_d   = a_dig_q;
      a_sp_d    = a_sp_q;
      b_dig_d   = b_dig_q;
      bad_d     = bad_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      go_d      = 1'b0;
      reset_d   = 1'b0;
      err_d     = 1'b0;
      bad_nx    = bad_q;

      unique case (state_q)
         StCollect: begin
            if (bus.char_valid) begin
               if (bus.char_in == 8'h08) begin
                  if (len_q != '0) len_d = len_q - LenW'(1);
               end else if (bus.char_in == 8'h0D) begin
                  if (len_q != '0) state_d = StKeyw;
               end else if (len_q == LenW'(MAX_CHARS)) begin
                  ovf_d = 1'b1;
               end else begin
                  for (int i = 0; i < MAX_CHARS; i++) begin
                     if (LenW'(i) == len_q) line_d[i] = bus.char_in;
                  end
                  len_d = len_q + LenW'(1);
               end
            end
         end
         StKeyw: begin
            state_d = StDone;
            if (ovf_q) begin
               err_d = 1'b1;
            end else if (kw_len && first5 == "reset") begin
               reset_d = 1'b1;
               op_d    = '0;
            end else if (kw_len && (first5 == "smile" || first5 == "fight")) begin
               go_d = 1'b1;
               a_d  = '0;
               b_d  = '0;
               op_d = (first5 == "smile") ? 11'h010 : 11'h020;
            end else begin
               state_d = StScan;
               idx_d   = '0;
            end
         end
         StScan: begin
            // Errors are sticky; the scan always runs the full line length.
            if (is_dig) begin
               if (!have_op_q && a_sp_q) bad_nx = 1'b1;
               if (acc_nx[AccW-1:OPW] != '0) bad_nx = 1'b1;
               acc_d = acc_nx;
               if (have_op_q) b_dig_d = 1'b1;
               else           a_dig_d = 1'b1;
            end else if (cur_ch == 8'h20) begin
               if ((!have_op_q && !a_dig_q) || (have_op_q && b_dig_q)) bad_nx = 1'b1;
               else if (!have_op_q) a_sp_d = 1'b1;
            end else if (is_op) begin
               if (have_op_q || !a_dig_q) begin
                  bad_nx = 1'b1;
               end else begin
                  have_op_d = 1'b1;
                  opa_d     = acc_q[OPW-1:0];
                  opc_d     = op_sel;
                  acc_d     = '0;
               end
            end else begin
               bad_nx = 1'b1;
            end
            bad_d = bad_nx;
            if (idx_q == len_q - LenW'(1)) begin
               state_d = StDone;
               // A valid line must end on a digit of operand B.
               if (!bad_nx && have_op_q && is_dig) begin
                  go_d = 1'b1;
                  a_d  = opa_q;
                  b_d  = acc_nx[OPW-1:0];
                  op_d = opc_q;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               idx_d = idx_q + LenW'(1);
            end
         end
         StDone: begin
            state_d   = StCollect;
            len_d     = '0;
            ovf_d     = 1'b0;
            acc_d     = '0;
            have_op_d = 1'b0;
            a_dig_d   = 1'b0;
            a_sp_d    = 1'b0;
            b_dig_d   = 1'b0;
            bad_d     = 1'b0;
         end
         default: state_d = StCollect;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StCollect;
         line_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         ovf_q     <= 1'b0;
         acc_q     <= '0;
         opa_q     <= '0;
         opc_q     <= '0;
         have_op_q <= 1'b0;
         a_dig_q   <= 1'b0;
         a_sp_q    <= 1'b0;
         b_dig_q   <= 1'b0;
         bad_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         go_q      <= 1'b0;
         reset_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         ovf_q     <= ovf_d;
         acc_q     <= acc_d;
         opa_q     <= opa_d;
         opc_q     <= opc_d;
         have_op_q <= have_op_d;
         a_dig_q   <= a_dig_d;
         a_sp_q    <= a_sp_d;
         b_dig_q   <= b_dig_d;
         bad_q     <= bad_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         go_q      <= go_d;
         reset_q   <= reset_d;
         err_q     <= err_d;
      end
   end

   assign bus.char_ready = state_q == StCollect;
   assign bus.a_in       = a_q;
   assign bus.b_in       = b_q;
   assign bus.op_code    = op_q;
   assign bus.go         = go_q;
   assign bus.reset      = reset_q;
   assign bus.err        = err_q;
endmodule

// File: doc/cmd_line_decoder.md
# cmd_line_decoder

Streaming successor to the fixed 40-bit five-character command decoder. It accepts ASCII characters one at a time from the terminal receive path over a valid/ready handshake and buffers them into a line of up to MAX_CHARS characters, with backspace support. On Enter it either matches a keyword or parses a decimal infix expression "A op B" into OPW-bit operands. It then issues one-cycle go/reset/err pulses to the calculator datapath.

## Interface
- MAX_CHARS, 8: line buffer depth in characters (≥5).
- OPW, 8: operand width in bits (2–16).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- char_in  in  8  ASCII character.
- char_valid  in  1  char_in valid; a transfer occurs when char_valid && char_ready.
- char_ready  out  1  decoder can accept a character.
- a_in  out  OPW  operand A, held until the next go.
- b_in  out  OPW  operand B, held until the next go.
- op_code  out  11  one-hot command code, held until the next go or reset pulse.
- reset  out  1  one-cycle pulse on the keyword "reset".
- go  out  1  one-cycle pulse when a_in/b_in/op_code are newly valid.
- err  out  1  one-cycle pulse on a malformed or overflowed line.

## Operation
- op_code bits:
  - 0 '+' (0x2B), 1 '-' (0x2D), 2 '*' (0x2A), 3 '/' (0x2F).
  - 4 "smile", 5 "fight".
  - 6–10 always 0.
- States: COLLECT, KEYW, SCAN, DONE.
- COLLECT (char_ready=1):
  - 0x08 (backspace) decrements len if len>0, otherwise ignored.
  - 0x0D (Enter) with len=0 is ignored and the state stays COLLECT.
  - 0x0D with len>0 moves to KEYW.
  - Any other character is written at buf[len] and len increments, if len<MAX_CHARS.
  - A character arriving with len=MAX_CHARS is dropped and sets the sticky ovf flag.
- KEYW (1 cycle, char_ready=0):
  - If ovf: err, go to DONE.
  - Else if len=5 and buf equals "reset", "smile" or "fight" (lowercase only): select that result, go to DONE.
  - Otherwise go to SCAN with idx=0.
- SCAN (one buffered character per cycle, char_ready=0). Grammar: digits+ space* op space* digits+.
  - Spaces (0x20) are allowed only between the operand and the operator.
  - Decimal accumulation: acc = acc*10 + digit, computed at OPW+4 bits.
  - err if acc exceeds 2^OPW−1.
  - err on any character outside the grammar, a missing operand, or a second operator.
  - Scanning stops at idx=len−1, then moves to DONE.
- DONE (1 cycle): assert exactly one of go / reset / err, then clear len, ovf and accumulators, and return to COLLECT.
  - go: a_in, b_in and op_code update in the same cycle.
  - reset: op_code cleared to 0; a_in and b_in unchanged.
  - err: a_in, b_in and op_code unchanged.
  - Keyword smile/fight: asserts go with a_in=b_in=0 and the keyword op_code bit set.
- Division by zero is not checked here; it is passed downstream.

## Timing
- Reset values (rst_n low, asynchronous): state=COLLECT, len=0, ovf=0, a_in=0, b_in=0, op_code=0, reset=0, go=0, err=0, char_ready=1.
- Enter is accepted in cycle T. char_ready drops from T+1 until DONE ends.
- Keyword line or ovf: DONE and the pulse occur at T+2; char_ready=1 again at T+3.
- Expression line of length L: SCAN runs T+2..T+1+L; the pulse occurs at T+2+L; char_ready=1 at T+3+L.
- Pulses are registered outputs, high for exactly one cycle, and mutually exclusive.
- char_valid while char_ready=0: no transfer; the source must hold the character.
- rst_n asserted in any state aborts the line immediately. No pulse is emitted for the aborted line.

## Test plan
- "12+34"+Enter, accepted at T -> go at T+7; a_in=12, b_in=34, op_code=11'h001; err=0.
- "13",0x08,"2 - 5"+Enter -> go; a_in=12, b_in=5, op_code=11'h002.
- "reset"+Enter, then "smile"+Enter:
  - "reset" -> reset pulse at T+2, op_code=0.
  - "smile" -> go, op_code=11'h010, a_in=b_in=0.
- "256+1"+Enter (OPW=8) -> err pulse, no go; outputs keep prior values. "255*2" -> go, a_in=255, b_in=2, op_code=11'h004.
- 9 digits then Enter (MAX_CHARS=8) -> err at T+2. "+5", "7/", "4++2" each -> err.
- Backpressure and reset:
  - Hold char_valid high with new characters during SCAN -> nothing captured until char_ready returns.
  - Drop rst_n mid-SCAN of "99-1" -> all outputs 0 next edge, no go; a fresh "1+1" is decoded correctly afterwards.
